// File: rtl/twiddle_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : twiddle_scheduler_if
//  Description : Handshake/framing bundle between the FFT sample source, the
//                twiddle scheduler and the shared complex multiplier.
//                master : drives Enable / in_valid / in_sop, observes outputs
//                slave  : the scheduler itself
//                Signals: Enable, in_valid, in_sop (to scheduler);
//                twiddle_re/im, mult_enable, out_valid, out_sop, out_eop,
//                busy, err (from scheduler).
//  Revision    : 1.0 - initial release
// ============================================================================
interface twiddle_scheduler_if #(
    parameter int WIDTH = 16
) ();
    logic             Enable;
    logic             in_valid;
    logic             in_sop;
    logic [WIDTH-1:0] twiddle_re;
    logic [WIDTH-1:0] twiddle_im;
    logic             mult_enable;
    logic             out_valid;
    logic             out_sop;
    logic             out_eop;
    logic             busy;
    logic             err;

    modport master (
        output Enable, in_valid, in_sop,
        input  twiddle_re, twiddle_im, mult_enable,
        input  out_valid, out_sop, out_eop, busy, err
    );

    modport slave (
        input  Enable, in_valid, in_sop,
        output twiddle_re, twiddle_im, mult_enable,
        output out_valid, out_sop, out_eop, busy, err
    );
endinterface
`default_nettype wire

// File: rtl/twiddle_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : twiddle_scheduler
//  Description : Sequences the shared complex multiplier between radix-2^2
//                stages of a 16-point FFT. Tracks the sample index inside each
//                16-sample frame, supplies the twiddle W16^e as the second
//                multiplier operand, drives the multiplier enable and delays
//                valid/sop/eop by the multiplier latency.
//  Ports       : clk, rst           - clock, synchronous active-high reset
//                bus (slave)        - Enable/in_valid/in_sop in;
//                                     twiddle_re/im, mult_enable, out_valid,
//                                     out_sop, out_eop, busy, err out
//  Options     : TWS_SOP_CHECK_EN   - when defined, a sop arriving mid-frame
//                                     sets the sticky err flag; otherwise err
//                                     is tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
module twiddle_scheduler #(
    parameter int WIDTH        = 16,
    parameter int FIXED_POINT  = 11,
    parameter int MULT_LATENCY = 1
) (
    input  wire logic          clk,
    input  wire logic          rst,
    twiddle_scheduler_if.slave bus
);

    // ROM constants are Q1.14; scale to the requested fraction width with
    // round-half-up (add half an output LSB before the arithmetic shift).
    localparam int C_SHIFT = 14 - FIXED_POINT;
    localparam int C_RND   = (1 << C_SHIFT) >> 1;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t                        state_q, state_d;
    logic [3:0]                    cnt_q, cnt_d;
    logic [WIDTH-1:0]              twiddle_re_q, twiddle_re_d;
    logic [WIDTH-1:0]              twiddle_im_q, twiddle_im_d;
    logic                          mult_enable_q, mult_enable_d;
    logic                          sop_flag_q, sop_flag_d;
    logic                          eop_flag_q, eop_flag_d;
    // Each stage packs {valid, sop, eop}.
    logic [MULT_LATENCY-1:0][2:0]  dly_q, dly_d;

    logic                          w_accept;
    logic [3:0]                    w_t;
    logic [3:0]                    w_e;
    int                            w_rom_re;
    int                            w_rom_im;
    logic                          w_busy;

    // ------------------------------------------------------------------------
    // Next-state / datapath
    // ------------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        twiddle_re_d  = twiddle_re_q;
        twiddle_im_d  = twiddle_im_q;
        mult_enable_d = mult_enable_q;
        sop_flag_d    = sop_flag_q;
        eop_flag_d    = eop_flag_q;
        dly_d         = dly_q;

        w_accept = bus.Enable & bus.in_valid & ((state_q == S_RUN) | bus.in_sop);
        // A sop always restarts the frame, both from IDLE and as a resync.
        w_t      = bus.in_sop ? 4'd0 : cnt_q;
        // t = {q,r}; exponent uses q bit-reversed (radix-2^2 ordering).
        w_e      = {2'b00, w_t[1:0]} * {2'b00, w_t[2], w_t[3]};

        w_rom_re = 0;
        w_rom_im = 0;
        case (w_e)
            4'd0:    begin w_rom_re =  16384; w_rom_im =      0; end
            4'd1:    begin w_rom_re =  15137; w_rom_im =  -6270; end
            4'd2:    begin w_rom_re =  11585; w_rom_im = -11585; end
            4'd3:    begin w_rom_re =   6270; w_rom_im = -15137; end
            4'd4:    begin w_rom_re =      0; w_rom_im = -16384; end
            4'd6:    begin w_rom_re = -11585; w_rom_im = -11585; end
            4'd9:    begin w_rom_re = -15137; w_rom_im =   6270; end
            default: begin w_rom_re =      0; w_rom_im =      0; end
        endcase

        if (w_accept) begin
            twiddle_re_d  = WIDTH'((w_rom_re + C_RND) >>> C_SHIFT);
            twiddle_im_d  = WIDTH'((w_rom_im + C_RND) >>> C_SHIFT);
            mult_enable_d = 1'b1;
            sop_flag_d    = (w_t == 4'd0);
            eop_flag_d    = (w_t == 4'd15);
            if (w_t == 4'd15) begin
                cnt_d   = 4'd0;
                state_d = S_IDLE;
            end else begin
                cnt_d   = w_t + 4'd1;
                state_d = S_RUN;
            end
        end else if (bus.Enable) begin
            // Twiddle holds its last value; only the enable/framing flags drop.
            mult_enable_d = 1'b0;
            sop_flag_d    = 1'b0;
            eop_flag_d    = 1'b0;
        end

        // Delay line models the multiplier pipeline; it advances only on
        // enabled cycles so framing stays aligned with the multiplier data.
        if (bus.Enable) begin
            dly_d[0] = {mult_enable_q, sop_flag_q, eop_flag_q};
            for (int i = 1; i < MULT_LATENCY; i++) begin
                dly_d[i] = dly_q[i-1];
            end
        end
    end

    // The mult_enable register is the first pipeline stage, so it counts
    // toward busy; this keeps busy continuous through gaps in in_valid.
    always_comb begin
        w_busy = (state_q == S_RUN) | mult_enable_q;
        for (int i = 0; i < MULT_LATENCY; i++) begin
            w_busy = w_busy | dly_q[i][2];
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= 4'd0;
            twiddle_re_q  <= '0;
            twiddle_im_q  <= '0;
            mult_enable_q <= 1'b0;
            sop_flag_q    <= 1'b0;
            eop_flag_q    <= 1'b0;
            dly_q         <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            twiddle_re_q  <= twiddle_re_d;
            twiddle_im_q  <= twiddle_im_d;
            mult_enable_q <= mult_enable_d;
            sop_flag_q    <= sop_flag_d;
            eop_flag_q    <= eop_flag_d;
            dly_q         <= dly_d;
        end
    end

`ifdef TWS_SOP_CHECK_EN
    // Sticky: a sop landing inside a running frame means the source lost
    // framing. The frame still resyncs; this only records the event.
    logic err_q, err_d;

    always_comb begin
        err_d = err_q | (w_accept & bus.in_sop & (state_q == S_RUN) & (cnt_q != 4'd0));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.twiddle_re  = twiddle_re_q;
    assign bus.twiddle_im  = twiddle_im_q;
    assign bus.mult_enable = mult_enable_q;
    assign bus.out_valid   = dly_q[MULT_LATENCY-1][2];
    assign bus.out_sop     = dly_q[MULT_LATENCY-1][1];
    assign bus.out_eop     = dly_q[MULT_LATENCY-1][0];
    assign bus.busy        = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_twiddle_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_twiddle_scheduler
//  Description : Directed self-checking bench for twiddle_scheduler at the
//                default parameters (WIDTH=16, FIXED_POINT=11,
//                MULT_LATENCY=1). Expected err follows TWS_SOP_CHECK_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_twiddle_scheduler;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   ov_cnt;
    int   sop_cnt;
    int   eop_cnt;

`ifdef TWS_SOP_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    twiddle_scheduler_if #(.WIDTH(16)) bus ();

    twiddle_scheduler #(
        .WIDTH        (16),
        .FIXED_POINT  (11),
        .MULT_LATENCY (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hand-computed W16^e at FIXED_POINT=11, indexed by frame position t.
    function automatic int exp_re(input int t);
        int q, r, e;
        q = t / 4;
        r = t % 4;
        e = r * (((q % 2) * 2) + (q / 2));
        case (e)
            0: return 2048;
            1: return 1892;
            2: return 1448;
            3: return 784;
            4: return 0;
            6: return -1448;
            9: return -1892;
            default: return 99999;
        endcase
    endfunction

    function automatic int exp_im(input int t);
        int q, r, e;
        q = t / 4;
        r = t % 4;
        e = r * (((q % 2) * 2) + (q / 2));
        case (e)
            0: return 0;
            1: return -784;
            2: return -1448;
            3: return -1892;
            4: return -2048;
            6: return -1448;
            9: return 784;
            default: return 99999;
        endcase
    endfunction

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: apply inputs, take the edge, settle 1 time unit past it.
    task automatic cyc(input logic en, input logic v, input logic s, input logic r = 1'b0);
        bus.Enable   = en;
        bus.in_valid = v;
        bus.in_sop   = s;
        rst          = r;
        @(posedge clk);
        #1;
        if (en && !r) begin
            ov_cnt  += int'(bus.out_valid);
            sop_cnt += int'(bus.out_sop);
            eop_cnt += int'(bus.out_eop);
        end
    endtask

    task automatic chk_tw(input string tag, input int t);
        chk($sformatf("%s_re_t%0d", tag, t), $signed(bus.twiddle_re), exp_re(t));
        chk($sformatf("%s_im_t%0d", tag, t), $signed(bus.twiddle_im), exp_im(t));
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        ov_cnt       = 0;
        sop_cnt      = 0;
        eop_cnt      = 0;
        rst          = 1'b1;
        bus.Enable   = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_sop   = 1'b0;

        // ---------------- reset state ----------------
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b1, 1'b1);
        chk("rst_re",   $signed(bus.twiddle_re), 0);
        chk("rst_im",   $signed(bus.twiddle_im), 0);
        chk("rst_men",  bus.mult_enable, 0);
        chk("rst_ov",   bus.out_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_err",  bus.err, 0);

        // ---------------- 1: back-to-back frame ----------------
        for (int k = 0; k < 16; k++) begin
            cyc(1'b1, 1'b1, k == 0);
            chk_tw("s1", k);
            chk($sformatf("s1_men_%0d", k),  bus.mult_enable, 1);
            chk($sformatf("s1_ov_%0d", k),   bus.out_valid, (k != 0));
            chk($sformatf("s1_sop_%0d", k),  bus.out_sop, (k == 1));
            chk($sformatf("s1_eop_%0d", k),  bus.out_eop, 0);
            chk($sformatf("s1_busy_%0d", k), bus.busy, 1);
        end
        cyc(1'b1, 1'b0, 1'b0);
        chk("s1_tail_men", bus.mult_enable, 0);
        chk("s1_tail_re",  $signed(bus.twiddle_re), -1892);
        chk("s1_tail_im",  $signed(bus.twiddle_im), 784);
        chk("s1_tail_ov",  bus.out_valid, 1);
        chk("s1_tail_eop", bus.out_eop, 1);
        chk("s1_tail_sop", bus.out_sop, 0);
        chk("s1_tail_busy", bus.busy, 1);
        cyc(1'b1, 1'b0, 1'b0);
        chk("s1_end_ov",   bus.out_valid, 0);
        chk("s1_end_eop",  bus.out_eop, 0);
        chk("s1_end_busy", bus.busy, 0);

        // ---------------- 2: valid without sop in IDLE ----------------
        for (int k = 0; k < 4; k++) begin
            cyc(1'b1, 1'b1, 1'b0);
            chk($sformatf("s2_men_%0d", k),  bus.mult_enable, 0);
            chk($sformatf("s2_ov_%0d", k),   bus.out_valid, 0);
            chk($sformatf("s2_busy_%0d", k), bus.busy, 0);
        end
        cyc(1'b1, 1'b1, 1'b1);
        chk("s2_start_re",  $signed(bus.twiddle_re), 2048);
        chk("s2_start_im",  $signed(bus.twiddle_im), 0);
        chk("s2_start_men", bus.mult_enable, 1);

        // ---------------- 3: resync sop at t=7 ----------------
        for (int k = 1; k < 7; k++) begin
            cyc(1'b1, 1'b1, 1'b0);
            chk_tw("s3a", k);
        end
        cyc(1'b1, 1'b1, 1'b1);
        chk("s3_rs_re",  $signed(bus.twiddle_re), 2048);
        chk("s3_rs_im",  $signed(bus.twiddle_im), 0);
        chk("s3_rs_err", bus.err, EXP_ERR);
        for (int k = 1; k < 16; k++) begin
            cyc(1'b1, 1'b1, 1'b0);
            chk_tw("s3b", k);
            if (k == 1) chk("s3_rs_osop", bus.out_sop, 1);
        end
        chk("s3_err_sticky", bus.err, EXP_ERR);
        cyc(1'b1, 1'b0, 1'b0);
        chk("s3_eop", bus.out_eop, 1);
        cyc(1'b1, 1'b0, 1'b0);
        chk("s3_busy", bus.busy, 0);

        // ---------------- 4: valid every other cycle ----------------
        ov_cnt = 0; sop_cnt = 0; eop_cnt = 0;
        for (int k = 0; k < 16; k++) begin
            cyc(1'b1, 1'b1, k == 0);
            chk_tw("s4", k);
            chk($sformatf("s4_men_%0d", k), bus.mult_enable, 1);
            cyc(1'b1, 1'b0, 1'b0);
            chk($sformatf("s4_gmen_%0d", k), bus.mult_enable, 0);
            chk_tw("s4g", k);
            chk($sformatf("s4_ov_%0d", k),   bus.out_valid, 1);
            chk($sformatf("s4_osop_%0d", k), bus.out_sop, (k == 0));
            chk($sformatf("s4_oeop_%0d", k), bus.out_eop, (k == 15));
            chk($sformatf("s4_busy_%0d", k), bus.busy, 1);
        end
        cyc(1'b1, 1'b0, 1'b0);
        chk("s4_busy_fall", bus.busy, 0);
        chk("s4_ov_cnt",    ov_cnt, 16);
        chk("s4_eop_cnt",   eop_cnt, 1);
        chk("s4_err",       bus.err, EXP_ERR);

        // reset clears sticky err
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        chk("rst2_err", bus.err, 0);

        // ---------------- 5: Enable low 3 cycles at t=6 ----------------
        ov_cnt = 0; sop_cnt = 0; eop_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            cyc(1'b1, 1'b1, k == 0);
            chk_tw("s5a", k);
        end
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, 1'b1, 1'b1);
            chk($sformatf("s5_frz_re_%0d", k),   $signed(bus.twiddle_re), 1448);
            chk($sformatf("s5_frz_im_%0d", k),   $signed(bus.twiddle_im), -1448);
            chk($sformatf("s5_frz_men_%0d", k),  bus.mult_enable, 1);
            chk($sformatf("s5_frz_ov_%0d", k),   bus.out_valid, 1);
            chk($sformatf("s5_frz_busy_%0d", k), bus.busy, 1);
        end
        for (int k = 6; k < 16; k++) begin
            cyc(1'b1, 1'b1, 1'b0);
            chk_tw("s5b", k);
        end
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        chk("s5_ov_cnt",  ov_cnt, 16);
        chk("s5_sop_cnt", sop_cnt, 1);
        chk("s5_eop_cnt", eop_cnt, 1);

        // ---------------- 6: reset mid-frame, then two frames ----------------
        for (int k = 0; k < 9; k++) begin
            cyc(1'b1, 1'b1, k == 0);
        end
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        chk("s6_rst_re",   $signed(bus.twiddle_re), 0);
        chk("s6_rst_im",   $signed(bus.twiddle_im), 0);
        chk("s6_rst_men",  bus.mult_enable, 0);
        chk("s6_rst_ov",   bus.out_valid, 0);
        chk("s6_rst_sop",  bus.out_sop, 0);
        chk("s6_rst_eop",  bus.out_eop, 0);
        chk("s6_rst_busy", bus.busy, 0);
        ov_cnt = 0; sop_cnt = 0; eop_cnt = 0;
        for (int k = 0; k < 32; k++) begin
            cyc(1'b1, 1'b1, (k % 16) == 0);
            chk($sformatf("s6_ov_%0d", k), bus.out_valid, (k != 0));
        end
        cyc(1'b1, 1'b0, 1'b0);
        chk("s6_last_ov",  bus.out_valid, 1);
        chk("s6_last_eop", bus.out_eop, 1);
        cyc(1'b1, 1'b0, 1'b0);
        chk("s6_ov_cnt",  ov_cnt, 32);
        chk("s6_sop_cnt", sop_cnt, 2);
        chk("s6_eop_cnt", eop_cnt, 2);
        chk("s6_busy",    bus.busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
